// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate extractor with a two-entry skid buffer.
// Registered in_ready; results leave in acceptance order with their tag.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_Z    = 3'd6;

  localparam logic SX = (SIGN_EXT != 0);

  logic [6:0]      op;
  logic            s;
  logic            is_i, is_s, is_b, is_j;
  logic            is_u, is_z, is_n;
  logic [31:0]     dec_imm32;
  logic            dec_ext;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  assign op = in_instr[6:0];
  assign s  = SX & in_instr[31];

  assign is_z = (op == 7'b1110011) & in_instr[14];
  assign is_i = (op == 7'b0010011) | (op == 7'b0000011)
              | (op == 7'b1100111)
              | ((op == 7'b1110011) & ~in_instr[14]);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_j = (op == 7'b1101111);
  assign is_u = (op == 7'b0110111) | (op == 7'b0010111);
  assign is_n = (op == 7'b0110011) | (op == 7'b0001111);

  always_comb begin
    dec_imm32 = '0;
    dec_fmt   = F_NONE;
    dec_ill   = 1'b0;
    dec_ext   = 1'b0;
    unique case (1'b1)
      is_i: begin
        dec_imm32 = {{20{s}}, in_instr[31:20]};
        dec_fmt   = F_I;
        dec_ext   = s;
      end
      is_s: begin
        dec_imm32 = {{20{s}}, in_instr[31:25],
                     in_instr[11:7]};
        dec_fmt   = F_S;
        dec_ext   = s;
      end
      is_b: begin
        dec_imm32 = {{19{s}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8],
                     1'b0};
        dec_fmt   = F_B;
        dec_ext   = s;
      end
      is_j: begin
        dec_imm32 = {{11{s}}, in_instr[31],
                     in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        dec_fmt   = F_J;
        dec_ext   = s;
      end
      is_u: begin
        dec_imm32 = {in_instr[31:12], 12'b0};
        dec_fmt   = F_U;
        dec_ext   = s;
      end
      is_z: begin
        dec_imm32 = {27'b0, in_instr[19:15]};
        dec_fmt   = F_Z;
      end
      is_n: begin
        dec_fmt   = F_NONE;
      end
      default: begin
        dec_ill   = 1'b1;
      end
    endcase
  end

  // Upper RV64 half follows the same fill bit as the 32-bit field.
  assign dec_imm = XLEN'({{32{dec_ext}}, dec_imm32});

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  logic in_xfer, load_out, skid_fill, skid_drain;

  assign in_xfer    = in_valid & in_ready;
  assign load_out   = ~out_valid | out_ready;
  assign skid_fill  = ~load_out & in_xfer;
  assign skid_drain = load_out & skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= '0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_fmt    <= '0;
      skid_ill    <= 1'b0;
      skid_tag    <= '0;
    end else begin
      in_ready <= ~((skid_valid & ~skid_drain) | skid_fill);
      if (load_out) begin
        if (skid_valid) begin
          out_valid   <= 1'b1;
          out_imm     <= skid_imm;
          out_fmt     <= skid_fmt;
          out_illegal <= skid_ill;
          out_tag     <= skid_tag;
          skid_valid  <= 1'b0;
        end else if (in_xfer) begin
          out_valid   <= 1'b1;
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_illegal <= dec_ill;
          out_tag     <= in_tag;
        end else begin
          out_valid   <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_valid <= 1'b1;
        skid_imm   <= dec_imm;
        skid_fmt   <= dec_fmt;
        skid_ill   <= dec_ill;
        skid_tag   <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three parameter sets share
// one input stream; results are checked against an arithmetic model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;

  logic        rdy, vld, ill;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [7:0]  tag;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;

  logic        rdyz, vldz, illz;
  logic [31:0] immz;
  logic [2:0]  fmtz;
  logic [7:0]  tagz;

  int passed = 0;
  int total = 0;

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1), .TAG_W(8)) u_s32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld), .out_ready(out_ready),
    .out_imm(imm), .out_fmt(fmt),
    .out_illegal(ill), .out_tag(tag));

  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1), .TAG_W(8)) u_s64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(tag64));

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(0), .TAG_W(8)) u_z32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdyz),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vldz), .out_ready(out_ready),
    .out_imm(immz), .out_fmt(fmtz),
    .out_illegal(illz), .out_tag(tagz));

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [31:0] iz;
    logic [3:0]  fi;
    logic [7:0]  t;
  } exp_t;

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                           7'h6F, 7'h37, 7'h17, 7'h73, 7'h33,
                           7'h0F};

  // Field value as an integer, then two's-complement wrap if signed.
  function automatic logic [63:0] ref_imm(input logic [31:0] x,
                                          input int xlen,
                                          input bit sx);
    longint v;
    int w;
    v = 0;
    w = 0;
    case (x[6:0])
      7'h13, 7'h03, 7'h67: begin
        v = longint'(x[31:20]); w = 12;
      end
      7'h23: begin
        v = longint'(x[31:25]) * 32 + longint'(x[11:7]); w = 12;
      end
      7'h63: begin
        v = longint'(x[31]) * 4096 + longint'(x[7]) * 2048
          + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2;
        w = 13;
      end
      7'h6F: begin
        v = longint'(x[31]) * 1048576 + longint'(x[19:12]) * 4096
          + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2;
        w = 21;
      end
      7'h37, 7'h17: begin
        v = longint'(x[31:12]) * 4096; w = 32;
      end
      7'h73: begin
        if (x[14]) v = longint'(x[19:15]);
        else begin v = longint'(x[31:20]); w = 12; end
      end
      default: v = 0;
    endcase
    if (sx && w > 0 && v[w-1]) v = v - (longint'(1) << w);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // {illegal, fmt}
  function automatic logic [3:0] ref_fi(input logic [31:0] x);
    case (x[6:0])
      7'h13, 7'h03, 7'h67: return 4'd1;
      7'h23: return 4'd2;
      7'h63: return 4'd3;
      7'h37, 7'h17: return 4'd4;
      7'h6F: return 4'd5;
      7'h73: return x[14] ? 4'd6 : 4'd1;
      7'h33, 7'h0F: return 4'd0;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] x,
                              input logic [7:0] t);
    exp_t e;
    e.i32 = ref_imm(x, 32, 1'b1)[31:0];
    e.i64 = ref_imm(x, 64, 1'b1);
    e.iz  = ref_imm(x, 32, 1'b0)[31:0];
    e.fi  = ref_fi(x);
    e.t   = t;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic test_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    total++; if (vld !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", vld); else passed++;
    total++; if (rdy !== 1'b0) $display("FAIL reset_ready got=%0h exp=0", rdy); else passed++;
    total++; if (imm !== 32'h0) $display("FAIL reset_imm got=%0h exp=0", imm); else passed++;
    total++; if (imm64 !== 64'h0) $display("FAIL reset_imm64 got=%0h exp=0", imm64); else passed++;
    total++; if ({ill, fmt} !== 4'h0) $display("FAIL reset_fmt got=%0h exp=0", {ill, fmt}); else passed++;
    total++; if (tag !== 8'h0) $display("FAIL reset_tag got=%0h exp=0", tag); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (rdy !== 1'b1) $display("FAIL post_reset_ready got=%0h exp=1", rdy); else passed++;
    total++; if (vld !== 1'b0) $display("FAIL post_reset_valid got=%0h exp=0", vld); else passed++;
  endtask

  task automatic test_directed();
    logic [31:0] ins [9] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7,
                             32'h3002D073, 32'h800000B7, 32'hFF9FF06F,
                             32'h00000000, 32'h0000007F, 32'h002081B3};
    logic [31:0] e32 [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                             32'h00000005, 32'h80000000, 32'hFFFFFFF8,
                             32'h0, 32'h0, 32'h0};
    logic [63:0] e64 [9] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
                             64'h00000000_12345000, 64'h5,
                             64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFF8,
                             64'h0, 64'h0, 64'h0};
    logic [31:0] ez [9]  = '{32'h00000FFF, 32'h00001FFC, 32'h12345000,
                             32'h00000005, 32'h80000000, 32'h001FFFF8,
                             32'h0, 32'h0, 32'h0};
    logic [3:0]  efi [9] = '{4'h1, 4'h3, 4'h4, 4'h6, 4'h4, 4'h5,
                             4'h8, 4'h8, 4'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = ins[i];
      in_tag   = 8'h11 + 8'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (vld !== 1'b1) $display("FAIL dir%0d_valid got=%0h exp=1", i, vld); else passed++;
      total++; if (imm !== e32[i]) $display("FAIL dir%0d_imm32 got=%h exp=%h", i, imm, e32[i]); else passed++;
      total++; if (imm64 !== e64[i]) $display("FAIL dir%0d_imm64 got=%h exp=%h", i, imm64, e64[i]); else passed++;
      total++; if (immz !== ez[i]) $display("FAIL dir%0d_immz got=%h exp=%h", i, immz, ez[i]); else passed++;
      total++; if ({ill, fmt} !== efi[i]) $display("FAIL dir%0d_fmt got=%h exp=%h", i, {ill, fmt}, efi[i]); else passed++;
      total++; if (tag !== 8'h11 + 8'(i)) $display("FAIL dir%0d_tag got=%h exp=%h", i, tag, 8'h11 + 8'(i)); else passed++;
    end
    @(posedge clk); #1;
    total++; if (vld !== 1'b0) $display("FAIL dir_drain_valid got=%0h exp=0", vld); else passed++;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit stalled;
    logic [31:0] cimm;
    logic [7:0]  ctag;
    stalled = 1'b0;
    cimm = '0;
    ctag = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      total++; if (rdy !== (q.size() < 2)) $display("FAIL rnd_ready got=%0h exp=%0h", rdy, q.size() < 2); else passed++;
      if (stalled) begin
        total++; if ({vld, imm, tag} !== {1'b1, cimm, ctag}) $display("FAIL rnd_stall_hold got=%h exp=%h", {vld, imm, tag}, {1'b1, cimm, ctag}); else passed++;
      end
      stalled = vld && !out_ready;
      cimm = imm;
      ctag = tag;
      if (vld && out_ready) begin
        total++;
        if (q.size() == 0) $display("FAIL rnd_spurious got=%h exp=none", tag);
        else begin
          e = q.pop_front();
          if ({imm, imm64, immz, ill, fmt, tag} !== {e.i32, e.i64, e.iz, e.fi, e.t})
            $display("FAIL rnd_result got=%h/%h/%h/%h/%h exp=%h/%h/%h/%h/%h",
                     imm, imm64, immz, {ill, fmt}, tag, e.i32, e.i64, e.iz, e.fi, e.t);
          else passed++;
        end
      end
      if (in_valid && rdy) q.push_back(mk(in_instr, in_tag));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vld) begin
        total++;
        if (q.size() == 0) $display("FAIL rnd_drain_spurious got=%h exp=none", tag);
        else begin
          e = q.pop_front();
          if ({imm, tag} !== {e.i32, e.t}) $display("FAIL rnd_drain got=%h/%h exp=%h/%h", imm, tag, e.i32, e.t);
          else passed++;
        end
      end
      @(posedge clk); #1;
    end
    total++; if (q.size() != 0) $display("FAIL rnd_lost got=%0d exp=0", q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int sent;
    bit stalled;
    bit rchk;
    logic [7:0] ctag;
    sent = 0;
    stalled = 1'b0;
    rchk = 1'b0;
    ctag = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 6);
      in_tag    = 8'(sent + 1);
      in_instr  = {4'h0, 8'(sent + 1), 20'h00093};
      @(negedge clk);
      if (sent == 2 && !rchk) begin
        rchk = 1'b1;
        total++; if (rdy !== 1'b0) $display("FAIL bp_ready_drop got=%0h exp=0", rdy); else passed++;
      end
      if (stalled) begin
        total++; if ({vld, tag} !== {1'b1, ctag}) $display("FAIL bp_stall_hold got=%h exp=%h", {vld, tag}, {1'b1, ctag}); else passed++;
      end
      stalled = vld && !out_ready;
      ctag = tag;
      if (vld && out_ready) begin
        got.push_back(tag);
        total++; if (imm !== {24'h0, tag}) $display("FAIL bp_imm got=%h exp=%h", imm, {24'h0, tag}); else passed++;
      end
      if (in_valid && rdy) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (got.size() != 6) $display("FAIL bp_count got=%0d exp=6", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 6; i++) begin
      total++; if (got[i] !== 8'(i + 1)) $display("FAIL bp_order%0d got=%0d exp=%0d", i, got[i], i + 1); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 8'hA1;
    @(posedge clk); #1;
    in_tag    = 8'hA2;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    total++; if ({vld, rdy} !== 2'b10) $display("FAIL mr_full got=%b exp=10", {vld, rdy}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (vld !== 1'b0) $display("FAIL mr_valid_now got=%0h exp=0", vld); else passed++;
    total++; if (tag !== 8'h0) $display("FAIL mr_tag_clear got=%h exp=0", tag); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (vld !== 1'b0) $display("FAIL mr_no_delivery got=%0h exp=0", vld); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if ({vld, rdy} !== 2'b01) $display("FAIL mr_release got=%b exp=01", {vld, rdy}); else passed++;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    in_tag   = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({vld, imm, tag} !== {1'b1, 32'h5, 8'h33}) $display("FAIL mr_after got=%h exp=%h", {vld, imm, tag}, {1'b1, 32'h5, 8'h33}); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
